fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle core's instruction/decode path. It replaces the zero-latency combinational instruction ROM lookup with a request/acknowledge port to a variable-latency instruction memory. It owns the fetch PC and buffers up to DEPTH fetched instructions, each tagged with its PC. It delivers them in order to the core over a valid/ready handshake, and flushes on a taken branch or jal redirect.

---
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to a
// variable-latency instruction memory, and buffers tagged words for the core.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_imem_addr;
  logic            r_imem_req;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_mem_pc   [DEPTH];
  logic [31:0]     r_mem_word [DEPTH];

  logic            w_push;
  logic            w_pop;

  // Data arriving in WAIT is kept only if no redirect lands on the same edge.
  assign w_push = (r_state == WAIT) && imem_ack && !redirect;
  assign w_pop  = (r_count != '0) && instr_ready;

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = r_mem_word[r_head];
  assign instr_pc    = r_mem_pc[r_head];
  assign count       = r_count;

  // NOTE: every register here is updated with <= so all state advances together
  // on the edge; blocking assignments would let later lines see half-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      // NOTE: storage is small and cleared on reset so instr/instr_pc read as
      // zero before the first fetch; large RAM-backed queues would skip this.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_word[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end else if (r_count < FULL) begin
            r_state     <= WAIT;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
          end
        end
        WAIT: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
            if (imem_ack) begin
              r_state    <= IDLE;
              r_imem_req <= 1'b0;
            end else begin
              // Keep the old address on the bus until the memory answers it.
              r_state <= DROP;
            end
          end else if (imem_ack) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
          end
        end
        DROP: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end
          if (imem_ack) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase

      if (w_push) begin
        r_mem_pc[r_tail]   <= r_fetch_pc;
        r_mem_word[r_tail] <= imem_rdata;
      end

      // A redirect flushes the queue and wins over any push or pop.
      if (redirect) begin
        r_count <= '0;
        r_head  <= r_tail;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, streaming, latency, redirects, async reset.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  bit          mem_auto;
  int          lat;
  int          wait_cnt;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory answers after `lat` idle cycles of a held request.
  task automatic mem_model();
    if (!imem_req) begin
      wait_cnt   = 0;
      imem_ack   = 1'b0;
    end else if (wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      wait_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mem_auto) mem_model();
  endtask

  task automatic manual_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] req_addrs [8];
    int          n_req;
    logic [31:0] exp_pc;
    int          pops;
    int          waits;
    bit          seen;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    mem_auto    = 1'b1;
    lat         = 0;
    wait_cnt    = 0;

    // Reset state
    #12;
    check("rst_req",   {31'b0, imem_req},    32'd0);
    check("rst_addr",  imem_addr,            32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_count", {29'b0, count},       32'd0);
    check("rst_instr", instr,                32'h0);
    check("rst_pc",    instr_pc,             32'h0);

    // Reset fill with zero-wait memory and no consumption
    @(negedge clk);
    rst_n = 1'b1;
    n_req = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (imem_req && imem_ack && n_req < 8) begin
        req_addrs[n_req] = imem_addr;
        n_req++;
      end
    end
    check("fill_nreq",  n_req,                32'd4);
    for (int i = 0; i < 4; i++) check("fill_addr", req_addrs[i], 32'(i * 4));
    check("fill_count", {29'b0, count},       32'd4);
    check("fill_req",   {31'b0, imem_req},    32'd0);
    check("fill_pc",    instr_pc,             32'h0);
    check("fill_instr", instr,                32'hA0);

    // Single pop while full: issue resumes one edge later
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("pop_count", {29'b0, count},    32'd3);
    check("pop_req0",  {31'b0, imem_req}, 32'd0);
    tick();
    check("pop_req1",  {31'b0, imem_req}, 32'd1);
    check("pop_addr",  imem_addr,         32'h10);

    // Streaming: in-order, gap-free consumption
    instr_ready = 1'b1;
    exp_pc = 32'h4;
    pops   = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        check("stream_pc",    instr_pc, exp_pc);
        check("stream_instr", instr,    mem_word(exp_pc));
        exp_pc += 32'd4;
        pops++;
      end
      tick();
    end
    instr_ready = 1'b0;
    check("stream_pops", {31'b0, (pops >= 10)}, 32'd1);

    // Variable latency: ack after three wait cycles
    lat         = 3;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("lat_flush_count", {29'b0, count},       32'd0);
    check("lat_flush_valid", {31'b0, instr_valid}, 32'd0);
    waits    = 0;
    seen     = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (prev_req && !prev_ack && imem_req) check("lat_addr_hold", imem_addr, prev_addr);
      if (imem_req && !imem_ack && imem_addr == 32'h100) waits++;
      if (imem_req && imem_ack && imem_addr == 32'h100) begin
        seen = 1'b1;
        check("lat_waits", waits, 32'd3);
        tick();
        check("lat_valid", {31'b0, instr_valid}, 32'd1);
        check("lat_count", {29'b0, count},       32'd1);
        check("lat_pc",    instr_pc,             32'h100);
        check("lat_instr", instr,                mem_word(32'h100));
      end else begin
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
        tick();
      end
    end
    check("lat_seen", {31'b0, seen}, 32'd1);

    // Redirect while waiting on 0x8, late ack discarded
    rst_n = 1'b0;
    #1;
    rst_n    = 1'b1;
    mem_auto = 1'b0;
    imem_ack = 1'b0;
    tick();
    manual_ack(mem_word(32'h0));
    tick();
    manual_ack(mem_word(32'h4));
    tick();
    check("rdw_req",  {31'b0, imem_req}, 32'd1);
    check("rdw_addr", imem_addr,         32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("rdw_count0", {29'b0, count},       32'd0);
    check("rdw_valid0", {31'b0, instr_valid}, 32'd0);
    check("rdw_drop_addr", imem_addr,         32'h8);
    tick();
    check("rdw_count1", {29'b0, count},       32'd0);
    manual_ack(32'hDEAD_BEEF);
    check("rdw_count2", {29'b0, count},       32'd0);
    check("rdw_req_off", {31'b0, imem_req},   32'd0);
    tick();
    check("rdw_new_req",  {31'b0, imem_req},  32'd1);
    check("rdw_new_addr", imem_addr,          32'h40);
    manual_ack(mem_word(32'h40));
    check("rdw_first_pc",    instr_pc,        32'h40);
    check("rdw_first_instr", instr,           mem_word(32'h40));

    // Redirect, pop and ack on one edge with two entries queued; PC wraps
    tick();
    manual_ack(mem_word(32'h44));
    check("sim_count2", {29'b0, count}, 32'd2);
    tick();
    check("sim_addr48", imem_addr, 32'h48);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    instr_ready = 1'b1;
    manual_ack(mem_word(32'h48));
    redirect    = 1'b0;
    instr_ready = 1'b0;
    check("sim_count", {29'b0, count},       32'd0);
    check("sim_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("sim_req",   {31'b0, imem_req},    32'd1);
    check("sim_addr",  imem_addr,            32'hFFFF_FFFC);
    manual_ack(mem_word(32'hFFFF_FFFC));
    check("wrap_pc",    instr_pc,            32'hFFFF_FFFC);
    check("wrap_count", {29'b0, count},      32'd1);
    tick();
    check("wrap_req",  {31'b0, imem_req},    32'd1);
    check("wrap_addr", imem_addr,            32'h0);

    // Asynchronous reset between edges while a request is outstanding
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_req",   {31'b0, imem_req},    32'd0);
    check("areset_valid", {31'b0, instr_valid}, 32'd0);
    check("areset_count", {29'b0, count},       32'd0);
    check("areset_addr",  imem_addr,            32'h0);
    check("areset_pc",    instr_pc,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
